// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

    localparam int W_DEF     = 32;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 32;

    // Register 0 is the hardwired zero register when ZERO_REG=1.
    localparam int ZERO_ADDR = 0;

    // Low bit of port k inside a packed bus whose per-port field is 'width' bits.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file.
//
// Protocol: there is no valid/ready handshake. Reads are combinational:
// rdata/rbusy follow raddr and the in-flight write ports in the same cycle.
// A write (weX=1) or busy-set (bset=1) is sampled on every rising clk edge
// and always accepted; the register file never stalls its producers.
interface regfile_mp_if #(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int NR = 2
) ();

    logic [NR*AW-1:0] raddr;
    logic [NR*W-1:0]  rdata;
    logic [NR-1:0]    rbusy;
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [W-1:0]     wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [W-1:0]     wdata1;
    logic             bset;
    logic [AW-1:0]    baddr;

    modport master (
        output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, bset, baddr,
        input  rdata, rbusy
    );

    modport slave (
        input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1, bset, baddr,
        output rdata, rbusy
    );

endinterface

// File: rtl/regfile_rport.sv
// One combinational read port: range check, zero register, bypass mux and
// busy lookup.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]    raddr,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [W-1:0]     wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [W-1:0]     wdata1,
    input  logic [W-1:0]     regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
    output logic [W-1:0]     rdata,
    output logic             rbusy
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [W-1:0] stored;
    logic         stored_busy;
    logic         in_range;
    logic         is_zero;

    // Select the stored word and busy bit; addresses past DEPTH match nothing.
    always_comb begin
        stored      = '0;
        stored_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                stored      = regs[i];
                stored_busy = busy[i];
            end
        end
    end

    assign in_range = ({1'b0, raddr} < DEPTH_L);
    assign is_zero  = (ZERO_REG != 0) && (raddr == AW'(ZERO_ADDR));

    // Resolve read data: nonexistent registers read 0, then port 1 bypass
    // beats port 0 bypass, which beats the stored value. Busy is never bypassed.
    always_comb begin
        rdata = stored;
        rbusy = stored_busy;
        if (!in_range || is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if ((BYPASS != 0) && we1 && (waddr1 == raddr)) begin
            rdata = wdata1;
        end else if ((BYPASS != 0) && we0 && (waddr0 == raddr)) begin
            rdata = wdata0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, two prioritised write ports, busy
// scoreboard and NR combinational read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W              = W_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int AW             = AW_DEF,
    parameter int NR             = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG       = 1,
    parameter int RESET_TO_INDEX = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] hit0;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hitb;

    // Per-register decode of the write and busy-set ports. Only existing,
    // writable registers can match, so out-of-range and zero-register
    // accesses fall away here.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        hitb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!((ZERO_REG != 0) && (i == ZERO_ADDR))) begin
                hit0[i] = bus.we0  && (bus.waddr0 == AW'(i));
                hit1[i] = bus.we1  && (bus.waddr1 == AW'(i));
                hitb[i] = bus.bset && (bus.baddr  == AW'(i));
            end
        end
    end

    // Storage: port 1 wins a same-address collision; reset loads index or 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (RESET_TO_INDEX != 0) ? W'(i) : '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit1[i]) begin
                    regs[i] <= bus.wdata1;
                end else if (hit0[i]) begin
                    regs[i] <= bus.wdata0;
                end
            end
        end
    end

    // Scoreboard: a retiring write clears busy unless a new producer sets it
    // in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hitb[i]) begin
                    busy[i] <= 1'b1;
                end else if (hit0[i] || hit1[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rport
        logic [AW-1:0] ra;
        logic [W-1:0]  rd;
        logic          rb;

        assign ra = bus.raddr[slice_lo(k, AW) +: AW];

        regfile_rport #(
            .W        (W),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .raddr  (ra),
            .we0    (bus.we0),
            .waddr0 (bus.waddr0),
            .wdata0 (bus.wdata0),
            .we1    (bus.we1),
            .waddr1 (bus.waddr1),
            .wdata1 (bus.wdata1),
            .regs   (regs),
            .busy   (busy),
            .rdata  (rd),
            .rbusy  (rb)
        );

        assign bus.rdata[slice_lo(k, W) +: W] = rd;
        assign bus.rbusy[k]                   = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations share one stimulus stream.
//   a: defaults (BYPASS=1, ZERO_REG=1, RESET_TO_INDEX=1, NR=2)
//   b: BYPASS=0
//   c: DEPTH=24, NR=4, ZERO_REG=0, RESET_TO_INDEX=0
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Shared drive variables.
    logic        we0, we1, bset;
    logic [4:0]  waddr0, waddr1, baddr;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  ra [4];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    regfile_mp_if #(.W(32), .AW(5), .NR(2)) bus_a ();
    regfile_mp_if #(.W(32), .AW(5), .NR(2)) bus_b ();
    regfile_mp_if #(.W(32), .AW(5), .NR(4)) bus_c ();

    assign bus_a.raddr = {ra[1], ra[0]};
    assign bus_b.raddr = {ra[1], ra[0]};
    assign bus_c.raddr = {ra[3], ra[2], ra[1], ra[0]};
    assign bus_a.we0 = we0; assign bus_a.waddr0 = waddr0; assign bus_a.wdata0 = wdata0;
    assign bus_a.we1 = we1; assign bus_a.waddr1 = waddr1; assign bus_a.wdata1 = wdata1;
    assign bus_a.bset = bset; assign bus_a.baddr = baddr;
    assign bus_b.we0 = we0; assign bus_b.waddr0 = waddr0; assign bus_b.wdata0 = wdata0;
    assign bus_b.we1 = we1; assign bus_b.waddr1 = waddr1; assign bus_b.wdata1 = wdata1;
    assign bus_b.bset = bset; assign bus_b.baddr = baddr;
    assign bus_c.we0 = we0; assign bus_c.waddr0 = waddr0; assign bus_c.wdata0 = wdata0;
    assign bus_c.we1 = we1; assign bus_c.waddr1 = waddr1; assign bus_c.wdata1 = wdata1;
    assign bus_c.bset = bset; assign bus_c.baddr = baddr;

    regfile_mp #(.W(32), .DEPTH(32), .AW(5), .NR(2), .BYPASS(1), .ZERO_REG(1), .RESET_TO_INDEX(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    regfile_mp #(.W(32), .DEPTH(32), .AW(5), .NR(2), .BYPASS(0), .ZERO_REG(1), .RESET_TO_INDEX(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    regfile_mp #(.W(32), .DEPTH(24), .AW(5), .NR(4), .BYPASS(1), .ZERO_REG(0), .RESET_TO_INDEX(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    // ---------------- reference model ----------------
    int cfg_depth [3] = '{32, 32, 24};
    int cfg_byp   [3] = '{1, 0, 1};
    int cfg_zero  [3] = '{1, 1, 0};
    int cfg_rti   [3] = '{1, 1, 0};
    int cfg_nr    [3] = '{2, 2, 4};
    logic [31:0] m_mem  [3][32];
    logic        m_busy [3][32];

    // An architectural register exists if it is below DEPTH and is not the zero register.
    function automatic bit m_valid(input int n, input logic [4:0] a);
        return (int'(a) < cfg_depth[n]) && !((cfg_zero[n] != 0) && (a == 5'd0));
    endfunction

    function automatic logic [31:0] m_read(input int n, input logic [4:0] a);
        if (!m_valid(n, a)) return 32'd0;
        if (cfg_byp[n] != 0 && we1 && waddr1 == a) return wdata1;
        if (cfg_byp[n] != 0 && we0 && waddr0 == a) return wdata0;
        return m_mem[n][a];
    endfunction

    function automatic logic m_rbusy(input int n, input logic [4:0] a);
        return m_valid(n, a) ? m_busy[n][a] : 1'b0;
    endfunction

    function automatic void m_reset();
        for (int n = 0; n < 3; n++)
            for (int i = 0; i < 32; i++) begin
                m_mem[n][i]  = (cfg_rti[n] != 0) ? 32'(i) : 32'd0;
                m_busy[n][i] = 1'b0;
            end
    endfunction

    function automatic void m_edge();
        for (int n = 0; n < 3; n++) begin
            bit ok0, ok1, okb;
            ok0 = we0 && m_valid(n, waddr0);
            ok1 = we1 && m_valid(n, waddr1);
            okb = bset && m_valid(n, baddr);
            if (ok0) begin m_mem[n][waddr0] = wdata0; m_busy[n][waddr0] = 1'b0; end
            if (ok1) begin m_mem[n][waddr1] = wdata1; m_busy[n][waddr1] = 1'b0; end
            if (okb) m_busy[n][baddr] = 1'b1;
        end
    endfunction

    // ---------------- DUT access and scoreboard ----------------
    function automatic logic [31:0] dut_rd(input int n, input int k);
        case (n)
            0:       return bus_a.rdata[k*32 +: 32];
            1:       return bus_b.rdata[k*32 +: 32];
            default: return bus_c.rdata[k*32 +: 32];
        endcase
    endfunction

    function automatic logic dut_rb(input int n, input int k);
        case (n)
            0:       return bus_a.rbusy[k];
            1:       return bus_b.rbusy[k];
            default: return bus_c.rbusy[k];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < cfg_nr[n]; k++) begin
                exp_q.push_back(m_read(n, ra[k]));
                exp_q.push_back({31'd0, m_rbusy(n, ra[k])});
            end
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < cfg_nr[n]; k++) begin
                chk($sformatf("%s dut%0d rdata%0d @%0d", tag, n, k, ra[k]), dut_rd(n, k), exp_q.pop_front());
                chk($sformatf("%s dut%0d rbusy%0d @%0d", tag, n, k, ra[k]), {31'd0, dut_rb(n, k)}, exp_q.pop_front());
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        bset = 1'b0; baddr = '0;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst_n) m_edge();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we0;  logic [4:0] wa0; logic [31:0] wd0;
        logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
        logic        bs;   logic [4:0] ba;
        logic [4:0]  r0;   logic [4:0] r1;
        logic [31:0] e_rd0; logic [31:0] e_rd1;
        logic        e_rb0; logic e_rb1;
        logic [31:0] e_b_rd0;
    } vec_t;

    function automatic vec_t mk(input int w0, input int a0, input logic [31:0] d0,
                                input int w1, input int a1, input logic [31:0] d1,
                                input int bs, input int ba, input int r0, input int r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input int b0, input int b1, input logic [31:0] eb);
        vec_t v;
        v.we0 = w0[0]; v.wa0 = 5'(a0); v.wd0 = d0;
        v.we1 = w1[0]; v.wa1 = 5'(a1); v.wd1 = d1;
        v.bs = bs[0];  v.ba = 5'(ba);
        v.r0 = 5'(r0); v.r1 = 5'(r1);
        v.e_rd0 = e0;  v.e_rd1 = e1;
        v.e_rb0 = b0[0]; v.e_rb1 = b1[0];
        v.e_b_rd0 = eb;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 6, 32'hDEADBEEF, 6, 0, 0, 5);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF);
        tbl[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 7, 8, 32'h5555, 8, 0, 0, 7);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h5555, 32'h5555, 0, 0, 32'h5555);
        tbl[6]  = mk(1, 10, 32'h111, 1, 11, 32'h222, 0, 0, 10, 11, 32'h111, 32'h222, 0, 0, 10);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 10, 9, 32'h111, 0, 0, 9);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9, 9, 1, 1, 9);
        tbl[9]  = mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 3, 32'h99, 3, 1, 0, 9);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 32'h99, 3, 0, 0, 32'h99);
        tbl[11] = mk(1, 9, 32'h77, 0, 0, 0, 1, 9, 9, 9, 32'h77, 32'h77, 0, 0, 32'h99);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h77, 32'h77, 1, 1, 32'h77);
        tbl[13] = mk(0, 0, 0, 1, 31, 32'hFFFF0000, 1, 0, 0, 31, 0, 32'hFFFF0000, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 32'hFFFF0000, 0, 0, 0);
    end

    // ---------------- test sequence ----------------
    initial begin
        idle();
        for (int k = 0; k < 4; k++) ra[k] = '0;

        // Reset values, observed while reset is still held.
        #1 rst_n = 1'b0;
        m_reset();
        for (int i = 0; i < 32; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i); ra[2] = 5'(i); ra[3] = 5'(i);
            #1;
            chk($sformatf("reset rdata a%0d", i), dut_rd(0, 0), (i == 0) ? 32'd0 : 32'(i));
            chk($sformatf("reset rbusy a%0d", i), {31'd0, dut_rb(0, 0)}, 32'd0);
            check_model("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: write, zero register, collision, bypass, scoreboard.
        for (int v = 0; v < 15; v++) begin
            @(negedge clk);
            we0 = tbl[v].we0; waddr0 = tbl[v].wa0; wdata0 = tbl[v].wd0;
            we1 = tbl[v].we1; waddr1 = tbl[v].wa1; wdata1 = tbl[v].wd1;
            bset = tbl[v].bs; baddr = tbl[v].ba;
            ra[0] = tbl[v].r0; ra[1] = tbl[v].r1; ra[2] = tbl[v].r0; ra[3] = tbl[v].r1;
            #1;
            chk($sformatf("vec%0d rdata0", v), dut_rd(0, 0), tbl[v].e_rd0);
            chk($sformatf("vec%0d rdata1", v), dut_rd(0, 1), tbl[v].e_rd1);
            chk($sformatf("vec%0d rbusy0", v), {31'd0, dut_rb(0, 0)}, {31'd0, tbl[v].e_rb0});
            chk($sformatf("vec%0d rbusy1", v), {31'd0, dut_rb(0, 1)}, {31'd0, tbl[v].e_rb1});
            chk($sformatf("vec%0d nobypass rdata0", v), dut_rd(1, 0), tbl[v].e_b_rd0);
            check_model($sformatf("vec%0d", v));
            clock_edge();
        end

        // Asynchronous reset between edges after writes and busy sets.
        @(negedge clk);
        idle();
        bset = 1'b1; baddr = 5'd12; we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hCAFE;
        ra[0] = 5'd12; ra[1] = 5'd5; ra[2] = 5'd12; ra[3] = 5'd5;
        #1 check_model("pre-areset");
        clock_edge();
        @(negedge clk);
        idle();
        we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'hBEEF;
        #1;
        chk("areset busy before", {31'd0, dut_rb(0, 0)}, 32'd1);
        chk("areset data before", dut_rd(0, 1), 32'hCAFE);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("areset busy cleared", {31'd0, dut_rb(0, 0)}, 32'd0);
        chk("areset data restored", dut_rd(0, 1), 32'd5);
        check_model("in-areset");
        @(posedge clk);
        @(negedge clk);
        idle();
        ra[0] = 5'd13; ra[1] = 5'd9; ra[2] = 5'd13; ra[3] = 5'd9;
        rst_n = 1'b1;
        #1;
        chk("write during reset lost", dut_rd(0, 0), 32'd13);
        check_model("post-areset");
        clock_edge();

        // Out-of-range depth and four independent read ports on dut c.
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h22;
        #1 check_model("depth w1");
        clock_edge();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd3;  wdata0 = 32'h33;
        we1 = 1'b1; waddr1 = 5'd30; wdata1 = 32'h3030;
        ra[0] = 5'd30; ra[1] = 5'd30; ra[2] = 5'd30; ra[3] = 5'd30;
        #1;
        chk("oor bypass c", dut_rd(2, 0), 32'd0);
        chk("in range bypass a", dut_rd(0, 0), 32'h3030);
        check_model("depth w2");
        clock_edge();
        @(negedge clk);
        idle();
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; ra[3] = 5'd30;
        #1;
        chk("c port0", dut_rd(2, 0), 32'h11);
        chk("c port1", dut_rd(2, 1), 32'h22);
        chk("c port2", dut_rd(2, 2), 32'h33);
        chk("c port3 oor", dut_rd(2, 3), 32'd0);
        check_model("depth read");
        clock_edge();

        // Randomised traffic against the model, with occasional reset pulses.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            we0 = ($urandom_range(0, 1) == 1);   waddr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
            we1 = ($urandom_range(0, 1) == 1);   waddr1 = 5'($urandom_range(0, 31)); wdata1 = $urandom;
            bset = ($urandom_range(0, 2) == 0);  baddr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) waddr1 = waddr0;
            if ($urandom_range(0, 3) == 0) baddr = waddr0;
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 4))
                    0:       ra[k] = waddr0;
                    1:       ra[k] = waddr1;
                    2:       ra[k] = baddr;
                    default: ra[k] = 5'($urandom_range(0, 31));
                endcase
            end
            #1 check_model($sformatf("rnd%0d", c));
            if (c % 97 == 50) begin
                rst_n = 1'b0;
                m_reset();
                #1 check_model($sformatf("rnd%0d reset", c));
                rst_n = 1'b1;
            end
            clock_edge();
        end

        @(negedge clk);
        idle();
        #1 check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
